mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port Memory instance between NUM_REQ requesters. The Memory has a combinational read and writes on the clock edge.
- Each requester uses a valid/ready command handshake. The block registers the granted command, drives the memory one cycle later, and returns a registered response one cycle after that.
- Sits between the datapath requesters (e.g. fetch and load/store) and the Memory instance.

Parameters:
- DATA_WIDTH, 1, memory word width; must equal the Memory instance's DATA_WIDTH.
- ADDR_WIDTH, 8, memory address width; must equal the Memory instance's ADDR_WIDTH.
- NUM_REQ, 2, number of requesters, 2..8.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-low.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_we  in  NUM_REQ  per-requester: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened, same slicing as req_addr.
- req_ready  out  NUM_REQ  one-hot or zero; command accepted this cycle.
- rsp_valid  out  NUM_REQ  one-hot or zero; response for requester i.
- rsp_we  out  1  echo of the completed command's we.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- mem_addr  out  ADDR_WIDTH  to Memory addr.
- mem_we  out  1  to Memory we.
- mem_din  out  DATA_WIDTH  to Memory din.
- mem_dout  in  DATA_WIDTH  from Memory dout (combinational read).
- busy  out  1  a command is in the issue or response stage.

Behaviour:
- Reset (rst=0, asynchronous):
  - req_ready, rsp_valid, rsp_we, rsp_rdata, mem_we, busy all 0; mem_addr and mem_din 0.
  - Round-robin pointer = 0; issue and response stages cleared.
  - In-flight commands are dropped with no response; a write not yet issued is not performed.
- Arbitration (combinational, each cycle):
  - Search req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - The first set bit wins; req_ready[winner]=1, all other bits 0.
  - No valid requests: req_ready=0 and ptr unchanged.
- Pointer update: on accept, ptr <= winner+1, wrapping NUM_REQ-1 -> 0.
  - A continuously requesting requester therefore waits at most NUM_REQ-1 accepts.
- Requester rules:
  - Once req_valid is high, req_valid/we/addr/wdata stay stable until req_ready.
  - Dropping valid before ready is a protocol violation; behaviour is undefined and the bench flags it.
- Pipeline (always advances, no backpressure), one accept per cycle max:
  - Cycle t: accept. Issue stage <= {winner, we, addr, wdata}, issue_v <= 1.
  - Cycle t+1: mem_addr/mem_we/mem_din driven from the issue stage.
    - mem_we = issue_v & we; the write commits at the end-of-cycle edge.
    - For reads, the response stage captures mem_dout.
  - Cycle t+2: rsp_valid[winner]=1 for exactly one cycle, with rsp_we and rsp_rdata (0 for writes).
- Latency and throughput:
  - Accept-to-response latency is 2 cycles for both reads and writes.
  - Sustained throughput is 1 command per cycle across all requesters.
- Hazards:
  - Write accepted at t and read of the same address accepted at t+1: the read returns the new data, because the write commits at the end of t+1 and the read samples during t+2.
  - Read accepted at t and write to the same address at t+1: the read returns the old data.
- Idle issue stage: mem_we=0; mem_addr/mem_din hold their last values.
- busy = issue_v | any(rsp_valid).
- Simultaneous reset deassertion with req_valid high: arbitration starts from ptr=0 in the first cycle with rst=1.

Test Plan:
- Reset then single read: preload mem[0x10]=1; req0 read 0x10 at cycle 1. Required: req_ready=01 in cycle 1; mem_addr=0x10 in cycle 2; rsp_valid=01 and rsp_rdata=1 in cycle 3.
- Round robin: req0 and req1 issue continuous reads (addr 0x01/0x02). Required: grants alternate 01,10,01,10; after reset the first grant is req0; no requester waits more than 1 accept.
- Write then read-back: req1 writes 1 to 0xFF at cycle t, then reads 0xFF at t+1. Required: mem_we=1 at t+1; rsp_we=1 at t+2; rsp_rdata=1 with rsp_we=0 at t+3.
- Read-before-write: mem[0x05]=0; req0 reads 0x05 at t, req1 writes 1 to 0x05 at t+1. Required: read response rsp_rdata=0; a later read of 0x05 returns 1.
- Reset mid-operation: rst asserted low in the cycle after accepting a write of 1 to 0x20 (mem[0x20]=0). Required: all outputs 0 immediately (asynchronous); no rsp_valid; mem[0x20] stays 0; ptr=0.
- Idle gaps: NUM_REQ=3, only req2 valid for 4 cycles. Required: req2 granted every cycle; ptr wraps to 0; busy=1 from the cycle after the first accept until 2 cycles after the last.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ requesters.
// Pipeline: accept -> issue (drives memory) -> registered response.
module mem_rr_arbiter #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic                          rsp_we,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_we,
  output logic [DATA_WIDTH-1:0]         mem_din,
  input  logic [DATA_WIDTH-1:0]         mem_dout,
  output logic                          busy
);

  localparam int unsigned NR    = NUM_REQ;
  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      winner;
  logic [PTR_W-1:0]      ptr_next;
  logic                  grant_any;
  logic                  accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  issue_v;
  logic [PTR_W-1:0]      issue_id;
  logic                  issue_we;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [DATA_WIDTH-1:0] issue_wdata;

  // Search from ptr, wrapping; the first valid requester wins.
  always_comb begin
    int unsigned idx;
    grant_any = 1'b0;
    winner    = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = (32'(ptr) + k) % NR;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        winner    = PTR_W'(idx);
        sel_we    = req_we[idx];
        sel_addr  = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Gated by rst so req_ready is low for the whole reset period, not just after it.
  assign accept   = grant_any & rst;
  assign ptr_next = (winner == PTR_W'(NR - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= '0;
      issue_v     <= 1'b0;
      issue_id    <= '0;
      issue_we    <= 1'b0;
      issue_addr  <= '0;
      issue_wdata <= '0;
    end else begin
      issue_v <= accept;
      if (accept) begin
        ptr         <= ptr_next;
        issue_id    <= winner;
        issue_we    <= sel_we;
        issue_addr  <= sel_addr;
        issue_wdata <= sel_wdata;
      end
    end
  end

  // Address/data hold their last values while idle; only the write strobe drops.
  assign mem_addr = issue_addr;
  assign mem_din  = issue_wdata;
  assign mem_we   = issue_v & issue_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
      if (issue_v) begin
        rsp_valid[issue_id] <= 1'b1;
        rsp_we              <= issue_we;
        rsp_rdata           <= issue_we ? '0 : mem_dout;
      end
    end
  end

  assign busy = issue_v | (|rsp_valid);

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: a 2-requester instance and a 3-requester
// instance, each attached to a behavioural single-port memory.
module tb_mem_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance A: NUM_REQ = 2
  logic [1:0]  req_valid_a, req_we_a, req_ready_a, rsp_valid_a;
  logic [15:0] req_addr_a;
  logic [1:0]  req_wdata_a;
  logic        rsp_we_a, mem_we_a, busy_a;
  logic [0:0]  rsp_rdata_a, mem_din_a, mem_dout_a;
  logic [7:0]  mem_addr_a;

  // Instance B: NUM_REQ = 3
  logic [2:0]  req_valid_b, req_we_b, req_ready_b, rsp_valid_b;
  logic [23:0] req_addr_b;
  logic [2:0]  req_wdata_b;
  logic        rsp_we_b, mem_we_b, busy_b;
  logic [0:0]  rsp_rdata_b, mem_din_b, mem_dout_b;
  logic [7:0]  mem_addr_b;

  mem_rr_arbiter #(.DATA_WIDTH(1), .ADDR_WIDTH(8), .NUM_REQ(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_we(req_we_a), .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .req_ready(req_ready_a), .rsp_valid(rsp_valid_a), .rsp_we(rsp_we_a), .rsp_rdata(rsp_rdata_a),
    .mem_addr(mem_addr_a), .mem_we(mem_we_a), .mem_din(mem_din_a), .mem_dout(mem_dout_a),
    .busy(busy_a)
  );

  mem_rr_arbiter #(.DATA_WIDTH(1), .ADDR_WIDTH(8), .NUM_REQ(3)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_we(req_we_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .req_ready(req_ready_b), .rsp_valid(rsp_valid_b), .rsp_we(rsp_we_b), .rsp_rdata(rsp_rdata_b),
    .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_din(mem_din_b), .mem_dout(mem_dout_b),
    .busy(busy_b)
  );

  // Behavioural memories: combinational read, clocked write, plus a preload port.
  logic [0:0] mem0 [0:255];
  logic [0:0] mem1 [0:255];
  logic       pl_en0, pl_en1;
  logic [7:0] pl_addr;
  logic [0:0] pl_data;

  always @(posedge clk) begin
    if (pl_en0)        mem0[pl_addr]    <= pl_data;
    else if (mem_we_a) mem0[mem_addr_a] <= mem_din_a;
  end
  always @(posedge clk) begin
    if (pl_en1)        mem1[pl_addr]    <= pl_data;
    else if (mem_we_b) mem1[mem_addr_b] <= mem_din_b;
  end
  assign mem_dout_a = mem0[mem_addr_a];
  assign mem_dout_b = mem1[mem_addr_b];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic preload(input bit which, input logic [7:0] a, input logic d);
    pl_addr = a;
    pl_data = d;
    pl_en0  = !which;
    pl_en1  = which;
    tick();
    pl_en0  = 1'b0;
    pl_en1  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sample();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    req_valid_a = '0; req_we_a = '0; req_addr_a = '0; req_wdata_a = '0;
    req_valid_b = '0; req_we_b = '0; req_addr_b = '0; req_wdata_b = '0;
    pl_en0 = 1'b0; pl_en1 = 1'b0; pl_addr = '0; pl_data = '0;
    #1;
    preload(1'b0, 8'h10, 1'b1);
    preload(1'b0, 8'h01, 1'b0);
    preload(1'b0, 8'h02, 1'b1);
    preload(1'b0, 8'hFF, 1'b0);
    preload(1'b0, 8'h05, 1'b0);
    preload(1'b0, 8'h20, 1'b0);
    preload(1'b1, 8'h30, 1'b1);

    // Reset state, with req0 already asserting a read of 0x10
    req_valid_a = 2'b01; req_addr_a[0 +: 8] = 8'h10;
    sample();
    chk("rst_req_ready", req_ready_a, 2'b00);
    chk("rst_rsp_valid", rsp_valid_a, 2'b00);
    chk("rst_rsp_we",    rsp_we_a,    1'b0);
    chk("rst_rsp_rdata", rsp_rdata_a, 1'b0);
    chk("rst_mem_we",    mem_we_a,    1'b0);
    chk("rst_mem_addr",  mem_addr_a,  8'h00);
    chk("rst_mem_din",   mem_din_a,   1'b0);
    chk("rst_busy",      busy_a,      1'b0);

    // Single read; reset released with valid already high
    tick(); rst = 1'b1;
    sample();
    chk("rd_ready", req_ready_a, 2'b01);
    chk("rd_busy0", busy_a, 1'b0);
    tick(); req_valid_a = 2'b00;
    sample();
    chk("rd_mem_addr", mem_addr_a, 8'h10);
    chk("rd_mem_we",   mem_we_a, 1'b0);
    chk("rd_busy1",    busy_a, 1'b1);
    tick();
    sample();
    chk("rd_rsp_valid", rsp_valid_a, 2'b01);
    chk("rd_rsp_rdata", rsp_rdata_a, 1'b1);
    chk("rd_rsp_we",    rsp_we_a, 1'b0);
    tick();
    sample();
    chk("rd_rsp_done", rsp_valid_a, 2'b00);
    chk("rd_idle",     busy_a, 1'b0);

    // Round robin between two continuously requesting readers
    tick(); do_reset();
    req_valid_a = 2'b11; req_we_a = 2'b00;
    req_addr_a[0 +: 8] = 8'h01; req_addr_a[8 +: 8] = 8'h02;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("rr_grant", req_ready_a, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i >= 2) begin
        chk("rr_rsp_valid", rsp_valid_a, (i % 2 == 0) ? 2'b01 : 2'b10);
        chk("rr_rsp_rdata", rsp_rdata_a, (i % 2 == 0) ? 1'b0 : 1'b1);
      end
      tick();
    end
    req_valid_a = 2'b00;
    sample();
    chk("rr_tail0_valid", rsp_valid_a, 2'b01);
    chk("rr_tail0_rdata", rsp_rdata_a, 1'b0);
    tick();
    sample();
    chk("rr_tail1_valid", rsp_valid_a, 2'b10);
    chk("rr_tail1_rdata", rsp_rdata_a, 1'b1);
    tick();
    sample();
    chk("rr_idle", busy_a, 1'b0);

    // Write then read-back of 0xFF by req1
    tick();
    req_valid_a = 2'b10; req_we_a = 2'b10; req_addr_a[8 +: 8] = 8'hFF; req_wdata_a = 2'b10;
    sample();
    chk("wr_ready", req_ready_a, 2'b10);
    tick(); req_we_a = 2'b00;
    sample();
    chk("wr_rd_ready", req_ready_a, 2'b10);
    chk("wr_mem_we",   mem_we_a, 1'b1);
    chk("wr_mem_addr", mem_addr_a, 8'hFF);
    chk("wr_mem_din",  mem_din_a, 1'b1);
    tick(); req_valid_a = 2'b00; req_wdata_a = 2'b00;
    sample();
    chk("wr_rsp_valid", rsp_valid_a, 2'b10);
    chk("wr_rsp_we",    rsp_we_a, 1'b1);
    chk("wr_rsp_rdata", rsp_rdata_a, 1'b0);
    chk("wr_mem_we_off", mem_we_a, 1'b0);
    tick();
    sample();
    chk("rb_rsp_valid", rsp_valid_a, 2'b10);
    chk("rb_rsp_we",    rsp_we_a, 1'b0);
    chk("rb_rsp_rdata", rsp_rdata_a, 1'b1);

    // Read-before-write on 0x05
    tick();
    req_valid_a = 2'b01; req_we_a = 2'b00; req_addr_a[0 +: 8] = 8'h05;
    sample();
    chk("rbw_rd_ready", req_ready_a, 2'b01);
    tick();
    req_valid_a = 2'b10; req_we_a = 2'b10; req_addr_a[8 +: 8] = 8'h05; req_wdata_a = 2'b10;
    sample();
    chk("rbw_wr_ready", req_ready_a, 2'b10);
    tick(); req_valid_a = 2'b00; req_we_a = 2'b00; req_wdata_a = 2'b00;
    sample();
    chk("rbw_rd_valid", rsp_valid_a, 2'b01);
    chk("rbw_rd_old",   rsp_rdata_a, 1'b0);
    tick();
    sample();
    chk("rbw_wr_valid", rsp_valid_a, 2'b10);
    chk("rbw_wr_we",    rsp_we_a, 1'b1);
    tick();
    req_valid_a = 2'b01; req_addr_a[0 +: 8] = 8'h05;
    sample();
    chk("rbw_re_ready", req_ready_a, 2'b01);
    tick(); req_valid_a = 2'b00;
    tick();
    sample();
    chk("rbw_re_valid", rsp_valid_a, 2'b01);
    chk("rbw_re_new",   rsp_rdata_a, 1'b1);

    // Reset in the cycle after accepting a write of 1 to 0x20 (ptr is 1 here)
    tick();
    req_valid_a = 2'b01; req_we_a = 2'b01; req_addr_a[0 +: 8] = 8'h20; req_wdata_a = 2'b01;
    sample();
    chk("mr_ready", req_ready_a, 2'b01);
    tick(); req_valid_a = 2'b00; req_we_a = 2'b00; req_wdata_a = 2'b00;
    #1 rst = 1'b0;
    #1;
    chk("mr_mem_we",    mem_we_a, 1'b0);
    chk("mr_mem_addr",  mem_addr_a, 8'h00);
    chk("mr_mem_din",   mem_din_a, 1'b0);
    chk("mr_busy",      busy_a, 1'b0);
    chk("mr_rsp_valid", rsp_valid_a, 2'b00);
    @(posedge clk); @(posedge clk); #1;
    chk("mr_mem20",      mem0[8'h20], 1'b0);
    chk("mr_no_rsp",     rsp_valid_a, 2'b00);
    rst = 1'b1;
    req_valid_a = 2'b11; req_addr_a[0 +: 8] = 8'h20; req_addr_a[8 +: 8] = 8'h02;
    sample();
    chk("mr_ptr0", req_ready_a, 2'b01);
    tick(); req_valid_a = 2'b00;
    tick();
    sample();
    chk("mr_rd_valid", rsp_valid_a, 2'b01);
    chk("mr_rd_old",   rsp_rdata_a, 1'b0);

    // NUM_REQ=3: only req2 valid for 4 cycles
    tick();
    req_valid_b = 3'b100; req_we_b = 3'b000; req_addr_b[16 +: 8] = 8'h30;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("gap_grant", req_ready_b, 3'b100);
      chk("gap_busy",  busy_b, (i > 0) ? 1'b1 : 1'b0);
      if (i == 2) begin
        chk("gap_rsp_valid", rsp_valid_b, 3'b100);
        chk("gap_rsp_rdata", rsp_rdata_b, 1'b1);
      end
      tick();
    end
    req_valid_b = 3'b000;
    sample();
    chk("gap_busy_t1", busy_b, 1'b1);
    tick();
    sample();
    chk("gap_busy_t2", busy_b, 1'b1);
    tick();
    sample();
    chk("gap_busy_t3", busy_b, 1'b0);
    tick();
    req_valid_b = 3'b111; req_addr_b = {3{8'h30}};
    sample();
    chk("gap_ptr_wrap", req_ready_b, 3'b001);
    tick(); req_valid_b = 3'b000;
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
